spectrum_uart_streamer: RTL and testbench

- Parametrised successor to the fixed CCD + UART loopback top level.
- Accepts host commands over the UART byte stream and owns the CCD SH integration value.
- Captures one CCD line of ADC samples into an internal buffer, then streams it to the UART transmitter as a framed packet.
- Sits between CCD_Interface/ADC sample path and the UART_TX/UART_RX instances.

---
 rtl/spectrum_uart_streamer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_spectrum_uart_streamer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_uart_streamer.sv
// spectrum_uart_streamer
// Parses host bytes from UART_RX ('S' hi lo = set SH value, 'C' = single capture,
// 'R' = continuous capture, 'X' = stop continuous), captures one CCD line of ADC
// samples into an internal buffer and streams it to UART_TX as
//   AA 55 len_hi len_lo {pix_hi pix_lo}*NUM_PIX [csum]
// Build option: define SPEC_CHECKSUM_EN to append one XOR checksum byte
// covering the data bytes (header excluded).
module spectrum_uart_streamer #(
  parameter int PIX_W      = 12,
  parameter int NUM_PIX    = 3648,
  parameter int SH_DEFAULT = 7
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_valid,
  output logic             rx_data_ready,
  output logic [7:0]       tx_data,
  output logic             tx_data_valid,
  input  logic             tx_data_ready,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic [15:0]      sh_pulse,
  output logic             busy,
  output logic             short_frame
);

  localparam int ADDR_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [15:0] PKT_PIX = 16'(NUM_PIX);

  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_HI   = 2'd1;
  localparam logic [1:0] CMD_LO   = 2'd2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_CAPTURE   = 3'd2;
  localparam logic [2:0] S_SEND_HDR  = 3'd3;
  localparam logic [2:0] S_SEND_DATA = 3'd4;
  localparam logic [2:0] S_SEND_CSUM = 3'd5;

  localparam logic [7:0] BYTE_S = 8'h53;
  localparam logic [7:0] BYTE_C = 8'h43;
  localparam logic [7:0] BYTE_R = 8'h52;
  localparam logic [7:0] BYTE_X = 8'h58;

  logic [1:0]        cmd_st_q, cmd_st_d;
  logic [7:0]        sh_hi_q, sh_hi_d;
  logic [15:0]       sh_q, sh_d;
  logic              cont_q, cont_d;
  logic [2:0]        st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        hdr_idx_q, hdr_idx_d;
  logic              phase_q, phase_d;
  logic              short_q, short_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              rx_rdy_q;
  logic              busy_q;
`ifdef SPEC_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              cap_req_s, clr_short_s, restart_s, can_load_s, wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [2:0]        end_st_s;
  logic [15:0]       pix16_s;
  logic [7:0]        data_byte_s;
  logic [PIX_W-1:0]  mem_q [NUM_PIX];
  logic [PIX_W-1:0]  rd_data_q;

  assign rx_data_ready = rx_rdy_q;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign sh_pulse      = sh_q;
  assign busy          = busy_q;
  assign short_frame   = short_q;

  // Command parser: decodes host bytes, assembles the SH value, raises capture requests.
  always_comb begin
    cmd_st_d    = cmd_st_q;
    sh_hi_d     = sh_hi_q;
    sh_d        = sh_q;
    cont_d      = cont_q;
    cap_req_s   = 1'b0;
    clr_short_s = 1'b0;
    if (rx_data_valid) begin
      case (cmd_st_q)
        CMD_IDLE: begin
          case (rx_data)
            BYTE_S: cmd_st_d = CMD_HI;
            BYTE_C: begin
              cap_req_s   = (st_q == S_IDLE);
              clr_short_s = 1'b1;
            end
            BYTE_R: begin
              cap_req_s   = (st_q == S_IDLE);
              clr_short_s = 1'b1;
              cont_d      = 1'b1;
            end
            BYTE_X:  cont_d   = 1'b0;
            default: cmd_st_d = CMD_IDLE;
          endcase
        end
        CMD_HI: begin
          sh_hi_d  = rx_data;
          cmd_st_d = CMD_LO;
        end
        CMD_LO: begin
          sh_d     = {sh_hi_q, rx_data};
          cmd_st_d = CMD_IDLE;
        end
        default: cmd_st_d = CMD_IDLE;
      endcase
    end else begin
      cmd_st_d = cmd_st_q;
    end
  end

  // Main FSM: arm on a request, capture one line, then stream header, data and optional checksum.
  always_comb begin
    st_d        = st_q;
    addr_d      = addr_q;
    rd_addr_d   = rd_addr_q;
    hdr_idx_d   = hdr_idx_q;
    phase_d     = phase_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = (tx_valid_q && tx_data_ready) ? 1'b0 : tx_valid_q;
    can_load_s  = !tx_valid_q || tx_data_ready;
    wr_en_s     = 1'b0;
    wr_addr_s   = frame_start ? '0 : addr_q;
    end_st_s    = cont_q ? S_ARM : S_IDLE;
    restart_s   = (st_q == S_CAPTURE) && frame_start && (addr_q != '0);
    short_d     = restart_s ? 1'b1 : (clr_short_s ? 1'b0 : short_q);
    pix16_s     = 16'h0000;
    pix16_s[PIX_W-1:0] = rd_data_q;
    data_byte_s = phase_q ? pix16_s[7:0] : pix16_s[15:8];
`ifdef SPEC_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (st_q)
      S_IDLE: begin
        if (cap_req_s) st_d = S_ARM;
        else           st_d = S_IDLE;
      end
      S_ARM, S_CAPTURE: begin
        if ((st_q == S_ARM) && !frame_start) begin
          st_d = S_ARM;
        end else begin
          st_d = S_CAPTURE;
          if (pix_valid) begin
            wr_en_s = 1'b1;
            if (wr_addr_s == LAST_ADDR) begin
              st_d      = S_SEND_HDR;
              addr_d    = '0;
              rd_addr_d = '0;
              hdr_idx_d = 2'd0;
              phase_d   = 1'b0;
`ifdef SPEC_CHECKSUM_EN
              csum_d    = 8'h00;
`endif
            end else begin
              addr_d = wr_addr_s + ADDR_W'(1);
            end
          end else begin
            addr_d = wr_addr_s;
          end
        end
      end
      S_SEND_HDR: begin
        if (can_load_s) begin
          tx_valid_d = 1'b1;
          case (hdr_idx_q)
            2'd0:    tx_data_d = 8'hAA;
            2'd1:    tx_data_d = 8'h55;
            2'd2:    tx_data_d = PKT_PIX[15:8];
            default: tx_data_d = PKT_PIX[7:0];
          endcase
          if (hdr_idx_q == 2'd3) st_d = S_SEND_DATA;
          else                   hdr_idx_d = hdr_idx_q + 2'd1;
        end else begin
          st_d = S_SEND_HDR;
        end
      end
      S_SEND_DATA: begin
        if (can_load_s) begin
          tx_valid_d = 1'b1;
          tx_data_d  = data_byte_s;
          phase_d    = !phase_q;
`ifdef SPEC_CHECKSUM_EN
          csum_d     = csum_q ^ data_byte_s;
`endif
          if (phase_q && (rd_addr_q == LAST_ADDR)) begin
`ifdef SPEC_CHECKSUM_EN
            st_d = S_SEND_CSUM;
`else
            st_d = end_st_s;
`endif
          end else if (phase_q) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end else begin
            rd_addr_d = rd_addr_q;
          end
        end else begin
          st_d = S_SEND_DATA;
        end
      end
`ifdef SPEC_CHECKSUM_EN
      S_SEND_CSUM: begin
        if (can_load_s) begin
          tx_valid_d = 1'b1;
          tx_data_d  = csum_q;
          st_d       = end_st_s;
        end else begin
          st_d = S_SEND_CSUM;
        end
      end
`endif
      default: st_d = S_IDLE;
    endcase
  end

  // Line buffer: write during capture, read continuously at the next read address.
  always_ff @(posedge clk_50m) begin
    if (wr_en_s) mem_q[wr_addr_s] <= pix_data;
    rd_data_q <= mem_q[rd_addr_d];
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      cmd_st_q   <= CMD_IDLE;
      sh_hi_q    <= 8'h00;
      sh_q       <= 16'(SH_DEFAULT);
      cont_q     <= 1'b0;
      st_q       <= S_IDLE;
      addr_q     <= '0;
      rd_addr_q  <= '0;
      hdr_idx_q  <= 2'd0;
      phase_q    <= 1'b0;
      short_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rx_rdy_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SPEC_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      cmd_st_q   <= cmd_st_d;
      sh_hi_q    <= sh_hi_d;
      sh_q       <= sh_d;
      cont_q     <= cont_d;
      st_q       <= st_d;
      addr_q     <= addr_d;
      rd_addr_q  <= rd_addr_d;
      hdr_idx_q  <= hdr_idx_d;
      phase_q    <= phase_d;
      short_q    <= short_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_rdy_q   <= 1'b1;
      busy_q     <= (st_d != S_IDLE);
`ifdef SPEC_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_spectrum_uart_streamer.sv
// Directed bench for spectrum_uart_streamer with NUM_PIX=4, PIX_W=12.
module tb_spectrum_uart_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_valid = 1'b0;
  logic        rx_data_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [11:0] pix_data = 12'h000;
  logic [15:0] sh_pulse;
  logic        busy;
  logic        short_frame;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic       bp_en = 1'b0;
  int         stall_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  spectrum_uart_streamer #(.PIX_W(12), .NUM_PIX(4), .SH_DEFAULT(7)) dut (
    .clk_50m(clk), .rst(rst),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_data(pix_data),
    .sh_pulse(sh_pulse), .busy(busy), .short_frame(short_frame)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Byte collector and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_valid", 16'(tx_data_valid), 16'h0001);
        check_eq("hold_data", 16'(tx_data), 16'(prev_data));
      end
      if (tx_data_valid && tx_data_ready) got.push_back(tx_data);
      stall_prev = tx_data_valid && !tx_data_ready;
      prev_data  = tx_data;
    end
  end

  // Ready driver: constant high, or toggling with one long stall mid-data.
  always @(posedge clk) begin
    #2;
    if (!bp_en) tx_data_ready = 1'b1;
    else if (got.size() == 7 && stall_cnt < 50) begin
      tx_data_ready = 1'b0;
      stall_cnt++;
    end else tx_data_ready = ~tx_data_ready;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_data_valid = 1'b1;
    step();
    rx_data_valid = 1'b0;
  endtask

  task automatic pulse_fs(input logic with_pix, input logic [11:0] v);
    frame_start = 1'b1; pix_valid = with_pix; pix_data = v;
    step();
    frame_start = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic feed_pix(input logic [11:0] v);
    pix_data = v; pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
  endtask

  task automatic build_exp(input logic [11:0] a, input logic [11:0] b,
                           input logic [11:0] c, input logic [11:0] d);
    logic [15:0] px [4];
    logic [7:0]  x;
    px[0] = {4'h0, a}; px[1] = {4'h0, b}; px[2] = {4'h0, c}; px[3] = {4'h0, d};
    exp_q.delete();
    exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
    exp_q.push_back(8'h00); exp_q.push_back(8'h04);
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(px[i][15:8]); exp_q.push_back(px[i][7:0]);
      x = x ^ px[i][15:8] ^ px[i][7:0];
    end
`ifdef SPEC_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) step();
  endtask

  task automatic cmp_pkt(input string tag);
    check_eq($sformatf("%s_len", tag), 16'(got.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), 16'(got[i]), 16'(exp_q[i]));
  endtask

  initial begin
    // Reset state
    step(); step();
    check_eq("rst_sh", sh_pulse, 16'h0007);
    check_eq("rst_txv", 16'(tx_data_valid), 16'h0000);
    check_eq("rst_txd", 16'(tx_data), 16'h0000);
    check_eq("rst_busy", 16'(busy), 16'h0000);
    check_eq("rst_short", 16'(short_frame), 16'h0000);
    check_eq("rst_rxrdy", 16'(rx_data_ready), 16'h0000);
    rst = 1'b0;
    step();
    check_eq("rel_rxrdy", 16'(rx_data_ready), 16'h0001);

    // SH update
    send_byte(8'h53); send_byte(8'h01);
    check_eq("sh_hold", sh_pulse, 16'h0007);
    send_byte(8'h2C);
    check_eq("sh_upd", sh_pulse, 16'h012C);
    check_eq("sh_busy", 16'(busy), 16'h0000);

    // Single capture
    got.delete();
    build_exp(12'hABC, 12'h001, 12'hFFF, 12'h123);
    send_byte(8'h43);
    check_eq("cap_busy", 16'(busy), 16'h0001);
    step();
    pulse_fs(1'b0, 12'h000);
    feed_pix(12'hABC); feed_pix(12'h001); feed_pix(12'hFFF); feed_pix(12'h123);
    step();
    check_eq("hdr_lat_v", 16'(tx_data_valid), 16'h0001);
    check_eq("hdr_lat_d", 16'(tx_data), 16'h00AA);
    wait_bytes(exp_q.size(), 200);
    repeat (5) step();
    cmp_pkt("single");
    check_eq("single_busy", 16'(busy), 16'h0000);

    // Backpressure, pixel 0 on the frame_start cycle
    got.delete();
    bp_en = 1'b1;
    send_byte(8'h43);
    pulse_fs(1'b1, 12'hABC);
    feed_pix(12'h001); feed_pix(12'hFFF); feed_pix(12'h123);
    wait_bytes(exp_q.size(), 600);
    bp_en = 1'b0;
    repeat (5) step();
    cmp_pkt("bp");
    check_eq("bp_stall", 16'(stall_cnt), 16'd50);

    // Line restart in continuous mode
    got.delete();
    build_exp(12'h001, 12'h002, 12'h003, 12'h004);
    send_byte(8'h52);
    pulse_fs(1'b0, 12'h000);
    feed_pix(12'h111); feed_pix(12'h222);
    pulse_fs(1'b0, 12'h000);
    check_eq("restart_short", 16'(short_frame), 16'h0001);
    feed_pix(12'h001); feed_pix(12'h002); feed_pix(12'h003); feed_pix(12'h004);
    wait_bytes(exp_q.size(), 200);
    repeat (5) step();
    cmp_pkt("cont1");
    check_eq("cont_arm_busy", 16'(busy), 16'h0001);
    check_eq("cont_arm_txv", 16'(tx_data_valid), 16'h0000);

    // Next line in continuous mode, 'X' sent mid-packet
    got.delete();
    build_exp(12'h005, 12'h006, 12'h007, 12'h008);
    pulse_fs(1'b0, 12'h000);
    feed_pix(12'h005); feed_pix(12'h006); feed_pix(12'h007); feed_pix(12'h008);
    wait_bytes(6, 100);
    send_byte(8'h58);
    wait_bytes(exp_q.size(), 200);
    repeat (5) step();
    cmp_pkt("cont2");
    check_eq("x_idle_busy", 16'(busy), 16'h0000);
    check_eq("x_short_kept", 16'(short_frame), 16'h0001);

    // Abort during data
    got.delete();
    send_byte(8'h43);
    check_eq("c_clr_short", 16'(short_frame), 16'h0000);
    pulse_fs(1'b1, 12'h0AA);
    feed_pix(12'h0BB); feed_pix(12'h0CC); feed_pix(12'h0DD);
    wait_bytes(6, 100);
    rst = 1'b1;
    #1;
    check_eq("abort_txv", 16'(tx_data_valid), 16'h0000);
    check_eq("abort_busy", 16'(busy), 16'h0000);
    check_eq("abort_sh", sh_pulse, 16'h0007);
    step(); step();
    rst = 1'b0;
    step();
    got.delete();
    build_exp(12'h0F0, 12'h00F, 12'h800, 12'h7FF);
    send_byte(8'h43);
    pulse_fs(1'b0, 12'h000);
    feed_pix(12'h0F0); feed_pix(12'h00F); feed_pix(12'h800); feed_pix(12'h7FF);
    wait_bytes(exp_q.size(), 200);
    repeat (20) step();
    cmp_pkt("fresh");
    check_eq("fresh_busy", 16'(busy), 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
